// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receive bus: raw keyboard lines in, decoded byte and status pulses out.
// The receiver takes the slave side; a keyboard model or consumer takes master.
interface ps2_scancode_rx_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2_clock, ps2_data,
    input  scancode, valid, parity_err, frame_err
  );

  modport slave (
    input  ps2_clock, ps2_data,
    output scancode, valid, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard clock, then
// decodes 11-bit frames into scancodes with parity, framing and timeout checks.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic          clk_in,
  input  logic          reset,
  ps2_scancode_rx_if.slave ps2
);
  localparam int          FW       = $clog2(FILTER_LEN + 1);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [15:0]   to_cnt;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [7:0]    scancode_reg;
  logic          valid_reg, parity_err_reg, frame_err_reg;
  logic          bit_edge, to_hit;

  assign bit_edge = filt_prev & ~filt_clk;
  assign to_hit   = (state != IDLE) && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2.ps2_clock;
      clk_s2  <= clk_s1;
      data_s1 <= ps2.ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock flips only once the new level has persisted FILTER_LEN cycles.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == IDLE || bit_edge) begin
      to_cnt <= '0;
    end else if (to_cnt != 16'hFFFF) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      parity_bit     <= 1'b0;
      scancode_reg   <= '0;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (bit_edge) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s2;
            state      <= STOP;
          end
          STOP: begin
            // Parity failure takes precedence over a bad stop bit.
            if (!(^{shift_reg, parity_bit})) begin
              parity_err_reg <= 1'b1;
            end else if (!data_s2) begin
              frame_err_reg <= 1'b1;
            end else begin
              scancode_reg <= shift_reg;
              valid_reg    <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (to_hit) begin
        frame_err_reg <= 1'b1;
        shift_reg     <= '0;
        bit_cnt       <= '0;
        state         <= IDLE;
      end
    end
  end

  assign ps2.scancode   = scancode_reg;
  assign ps2.valid      = valid_reg;
  assign ps2.parity_err = parity_err_reg;
  assign ps2.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are driven bit by bit, the
// expected outcome is queued, and a monitor pops it when a pulse appears.
module tb_ps2_scancode_rx;
  localparam int HALF = 20;

  typedef struct {
    int         kind;     // 0 valid, 1 parity_err, 2 frame_err
    logic [7:0] code;     // scancode expected while the pulse is high
    bit         is_to;    // timeout abort, latency checked
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stall_cyc = 0;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT(50000)) dut (
    .clk_in (clk),
    .reset  (rst_n),
    .ps2    (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] code, input bit is_to);
    exp_t e;
    e.kind = kind; e.code = code; e.is_to = is_to;
    q.push_back(e);
    if (kind == 0) last_good = code;
  endtask

  task automatic glitch(input int n);
    bus.ps2_clock = 1'b0;
    wait_cyc(n);
    bus.ps2_clock = 1'b1;
    wait_cyc(HALF);
  endtask

  // Drives the first nbits of a frame; glitch_at >= 0 inserts a 3-cycle low
  // glitch on the clock just before that bit.
  task automatic send(input logic [7:0] d, input bit par_flip, input bit stop,
                      input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) glitch(3);
      bus.ps2_data = f[i];
      wait_cyc(HALF);
      bus.ps2_clock = 1'b0;
      stall_cyc = cyc;
      wait_cyc(HALF);
      bus.ps2_clock = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit par_flip, input bit stop);
    if (par_flip)   push(1, last_good, 1'b0);
    else if (!stop) push(2, last_good, 1'b0);
    else            push(0, d, 1'b0);
    send(d, par_flip, stop, 11, -1);
  endtask

  // Monitor: pops the scoreboard on each pulse and watches pulse shape.
  logic [2:0] prev_p = 3'b000;
  logic [7:0] prev_sc = 8'h00;
  always @(negedge clk) begin
    logic [2:0] p;
    exp_t e;
    int kind;
    p = {bus.valid, bus.parity_err, bus.frame_err};
    if (rst_n) begin
      if (bus.scancode !== prev_sc) chk("sc_change_with_valid", bus.valid, 1);
      if (p != 3'b000) begin
        chk("onehot", ($countones(p) <= 1), 1);
        chk("pulse_width", (prev_p & p), 0);
        if (q.size() == 0) begin
          chk("spurious_pulse", p, 0);
        end else begin
          e = q.pop_front();
          kind = bus.valid ? 0 : (bus.parity_err ? 1 : 2);
          chk("kind", kind, e.kind);
          chk("scancode", bus.scancode, e.code);
          if (e.is_to)
            chk("timeout_latency", ((cyc - stall_cyc) >= 49995 && (cyc - stall_cyc) <= 50030), 1);
          $display("pulse kind=%0d scancode=0x%02h cycle=%0d", kind, bus.scancode, cyc);
        end
      end
    end
    prev_p  = p;
    prev_sc = bus.scancode;
  end

  initial begin
    bus.ps2_clock = 1'b1;
    bus.ps2_data  = 1'b1;
    wait_cyc(5);
    chk("rst_scancode", bus.scancode, 8'h00);
    chk("rst_pulses", {bus.valid, bus.parity_err, bus.frame_err}, 0);
    rst_n = 1'b1;
    wait_cyc(30);
    chk("idle_scancode", bus.scancode, 8'h00);

    frame(8'h1C, 1'b0, 1'b1); wait_cyc(40);
    frame(8'h1C, 1'b1, 1'b1); wait_cyc(40);
    frame(8'h5A, 1'b0, 1'b0); wait_cyc(40);
    frame(8'h33, 1'b1, 1'b0); wait_cyc(40);

    push(2, last_good, 1'b1);
    send(8'hA5, 1'b0, 1'b1, 5, -1);
    wait_cyc(60000);
    frame(8'h5A, 1'b0, 1'b1); wait_cyc(40);

    glitch(4);
    push(0, 8'h29, 1'b0);
    send(8'h29, 1'b0, 1'b1, 11, 6);
    wait_cyc(40);

    frame(8'hF0, 1'b0, 1'b1);
    frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(40);

    send(8'h77, 1'b0, 1'b1, 5, -1);
    wait_cyc(5);
    rst_n = 1'b0;
    wait_cyc(3);
    chk("midframe_rst_scancode", bus.scancode, 8'h00);
    last_good = 8'h00;
    rst_n = 1'b1;
    wait_cyc(30);
    frame(8'h45, 1'b0, 1'b1); wait_cyc(40);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
